fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Circular instruction buffer between instruction fetch and the two-wide decode stage of the superscalar core.
- Accepts up to 2 fetched {pc, ir} pairs per cycle and presents up to 2 oldest entries, in program order, to the two decoders.
- Decouples imem fetch from decode/issue stalls and is emptied on branch redirect.

Parameters:
- DEPTH, 8: number of entries; must be a power of 2 and at least 4.
- NOP_IR, 32'h00000013: instruction word driven on an invalid output slot (addi x0,x0,0), so the decoders never raise is_halt on a bubble.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  redirect; empties the queue
- enq_num  in  2  entries offered this cycle: 0, 1 or 2; value 3 is treated as 0
- enq0_pc / enq0_ir  in  32 / 32  older fetched pair
- enq1_pc / enq1_ir  in  32 / 32  younger fetched pair
- enq_ready  out  1  at least 2 free entries
- deq_num  in  2  entries consumed this cycle: 0, 1 or 2
- out0_valid  out  1  head entry valid
- out0_pc / out0_ir  out  32 / 32  head entry
- out1_valid  out  1  head+1 entry valid
- out1_pc / out1_ir  out  32 / 32  head+1 entry
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH×64-bit register array; head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count register.
- Reset (rst_n=0 at a clk edge): head=tail=count=0.
  - out0_valid=out1_valid=0, out*_pc=0, out*_ir=NOP_IR, enq_ready=1.
  - Array contents are don't-care.
- enq_ready = (DEPTH - count) >= 2; computed from registered count only, with no same-cycle dequeue credit.
- Enqueue (clk edge, enq_ready=1, flush=0):
  - Write enq_num entries at tail; enq0 first, then enq1 at tail+1 (wrapped).
  - tail += enq_num.
  - If enq_ready=0, the whole offer is dropped; partial enqueue never occurs. Fetch must hold its pair.
- Outputs are combinational reads of the head entries.
  - out0_valid = count>=1; out1_valid = count>=2.
  - An invalid slot drives pc=0, ir=NOP_IR.
  - Enqueue→visible latency is 1 cycle. There is no empty-queue bypass.
- Dequeue:
  - Effective take = min(deq_num, valid entries); deq_num=3 is treated as 0; excess requests are silently clamped.
  - head += take.
  - Slot order is strict: taking 1 always removes out0.
- Simultaneous enqueue and dequeue: count_next = count + enq_accepted - take. A full-to-empty or wrapping update within one edge must be exact.
- flush=1 (and rst_n=1):
  - head=tail=count=0 next cycle; the same-cycle enqueue and dequeue are ignored.
  - Outputs show bubbles on the following cycle.
- Priority: reset > flush > enqueue/dequeue.
- Reset or flush mid-burst leaves no stale valid entries.
- count never exceeds DEPTH.

Optional Feature:
- Macro FETCHQ_STATS_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each cycle with enq_num!=0 and enq_ready=0.
  - flush_count increments each cycle with flush=1.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with enq_num=2 held → out0/1_valid=0, out0_ir=out1_ir=32'h00000013, count=0, enq_ready=1; no entry is written.
- Enqueue pairs (pc 0x0/0x4), then (0x8/0xC) with deq_num=0 → next cycles show out0_pc=0x0, out1_pc=0x4, count=2 then 4; deq_num=1 → out0_pc=0x4, out1_pc=0x8.
- Fill to 8 (DEPTH=8) → enq_ready=0 at count=7 and 8; an offered pair during full is dropped, count stays 8, and the order is unchanged after draining.
- Steady state enq_num=2 and deq_num=2 for 20 cycles across pointer wrap → count constant, pcs monotonically +4 with no gaps or duplicates.
- count=1, deq_num=2 → take clamps to 1, count=0, no underflow; out0_valid=0 next cycle.
- count=5 with enq_num=2, deq_num=1, flush=1 → count=0 next cycle, both slots NOP_IR; under FETCHQ_STATS_EN, flush_count=1.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: two-in/two-out circular fetch buffer feeding dual decode (FETCHQ_STATS_EN adds stall_cycles/flush_count outputs)
module fetch_queue #(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] NOP_IR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [1:0]             enq_num,
  input  logic [31:0]            enq0_pc,
  input  logic [31:0]            enq0_ir,
  input  logic [31:0]            enq1_pc,
  input  logic [31:0]            enq1_ir,
  output logic                   enq_ready,
  input  logic [1:0]             deq_num,
  output logic                   out0_valid,
  output logic [31:0]            out0_pc,
  output logic [31:0]            out0_ir,
  output logic                   out1_valid,
  output logic [31:0]            out1_pc,
  output logic [31:0]            out1_ir,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCHQ_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            flush_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] head, tail, h1, t1;
  logic [AW:0]   enq_n, deq_req, take;
  logic [63:0]   e0, e1;
  always_comb begin
    enq_ready  = count <= (AW+1)'(DEPTH - 2);
    enq_n      = (enq_ready && enq_num != 2'd3) ? (AW+1)'(enq_num) : '0;
    deq_req    = deq_num == 2'd3 ? '0 : (AW+1)'(deq_num);
    take       = deq_req > count ? count : deq_req;
    h1         = head + AW'(1);
    t1         = tail + AW'(1);
    e0         = mem[head];
    e1         = mem[h1];
    out0_valid = count != '0;
    out1_valid = count > (AW+1)'(1);
    out0_pc    = out0_valid ? e0[63:32] : '0;
    out0_ir    = out0_valid ? e0[31:0] : NOP_IR;
    out1_pc    = out1_valid ? e1[63:32] : '0;
    out1_ir    = out1_valid ? e1[31:0] : NOP_IR;
  end
  always_ff @(posedge clk)
    if (rst_n && !flush) begin
      if (enq_n != '0) mem[tail] <= {enq0_pc, enq0_ir};
      if (enq_n == (AW+1)'(2)) mem[t1] <= {enq1_pc, enq1_ir};
    end
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + take[AW-1:0];
      tail  <= tail + enq_n[AW-1:0];
      count <= count + enq_n - take;
    end
`ifdef FETCHQ_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (enq_num != 2'd0 && !enq_ready) stall_cycles <= stall_cycles + 32'd1;
      if (flush) flush_count <= flush_count + 32'd1;
    end
`endif
endmodule
